// File: rtl/ulaw_pkg.sv
// Shared constants and code layout for the fix14 -> mu-law encoder.
`timescale 1ns/1ps
package ulaw_pkg;

  localparam int FIX14_W      = 14;
  localparam int ULAW_W       = 8;
  localparam int BIASED_W     = 13;
  localparam int ULAW_BIAS    = 33;
  localparam int ULAW_MAG_MAX = 8158;

  typedef struct packed {
    logic       sign;
    logic [2:0] chord;
    logic [3:0] val;
  } ulaw_code_t;

  // mu-law transmits the bitwise complement of {sign, chord, val}.
  function automatic logic [ULAW_W-1:0] ulaw_pack(input logic       sign,
                                                  input logic [2:0] chord,
                                                  input logic [3:0] val);
    ulaw_code_t code;
    code.sign  = sign;
    code.chord = chord;
    code.val   = val;
    return ~code;
  endfunction

endpackage

// File: rtl/ulaw_chord_find.sv
// Segment (chord) and 4-bit mantissa extraction from a biased 13-bit magnitude.
`timescale 1ns/1ps
module ulaw_chord_find
  import ulaw_pkg::*;
(
  input  logic [BIASED_W-1:0] i_biased,
  output logic [2:0]          o_chord,
  output logic [3:0]          o_val
);

  // Bit 0 sits below the finest quantization step and never reaches the code.
  logic w_unused_lsb;
  assign w_unused_lsb = i_biased[0];

  // Bias guarantees bit 5 is set, so the search only spans bits 5..12.
  always_comb begin
    o_chord = '0;
    for (int i = 5; i < BIASED_W; i++) begin
      if (i_biased[i]) o_chord = 3'(i - 5);
    end
    o_val = i_biased[{1'b0, o_chord} + 4'd1 +: 4];
  end

endmodule

// File: rtl/fix14_to_ulaw_enc.sv
// Two-stage valid/ready pipeline converting signed fix14 samples to mu-law codes,
// with a saturating count of clipped samples delivered downstream.
`timescale 1ns/1ps
module fix14_to_ulaw_enc
  import ulaw_pkg::*;
#(
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FIX14_W-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ULAW_W-1:0]    out_data,
  output logic                 out_sat,
  input  logic                 sat_clr,
  output logic [SAT_CNT_W-1:0] sat_count
);

  logic                 r_s1_valid;
  logic                 r_s1_sign;
  logic                 r_s1_sat;
  logic [BIASED_W-1:0]  r_s1_biased;
  logic                 r_s2_valid;
  logic [ULAW_W-1:0]    r_out_data;
  logic                 r_out_sat;
  logic [SAT_CNT_W-1:0] r_sat_count;

  logic                 w_s2_adv;
  logic                 w_s1_adv;
  logic [FIX14_W:0]     w_ext;
  logic [FIX14_W:0]     w_mag;
  logic                 w_sat;
  logic [BIASED_W-1:0]  w_clip;
  logic [BIASED_W-1:0]  w_biased;
  logic [2:0]           w_chord;
  logic [3:0]           w_val;
  logic                 w_sat_inc;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  // 15-bit magnitude so that -8192 negates to +8192 before clipping.
  assign w_ext    = {in_data[FIX14_W-1], in_data};
  assign w_mag    = in_data[FIX14_W-1] ? ((FIX14_W+1)'(0) - w_ext) : w_ext;
  assign w_sat    = w_mag > (FIX14_W+1)'(ULAW_MAG_MAX);
  assign w_clip   = w_sat ? BIASED_W'(ULAW_MAG_MAX) : w_mag[BIASED_W-1:0];
  assign w_biased = w_clip + BIASED_W'(ULAW_BIAS);

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the pre-edge value of its neighbour; blocking here would collapse stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_sat    <= 1'b0;
      r_s1_biased <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign   <= in_data[FIX14_W-1];
        r_s1_sat    <= w_sat;
        r_s1_biased <= w_biased;
      end
    end
  end

  ulaw_chord_find u_chord_find (
    .i_biased (r_s1_biased),
    .o_chord  (w_chord),
    .o_val    (w_val)
  );

  // Output register idles at 0xFF, the code for a zero sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_out_data <= '1;
      r_out_sat  <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= ulaw_pack(r_s1_sign, w_chord, w_val);
        r_out_sat  <= r_s1_sat;
      end
    end
  end

  assign w_sat_inc = r_s2_valid && out_ready && r_out_sat;

  // Clear takes priority over a coincident increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat_count <= '0;
    end else if (sat_clr) begin
      r_sat_count <= '0;
    end else if (w_sat_inc && (r_sat_count != '1)) begin
      r_sat_count <= r_sat_count + 1'b1;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign sat_count = r_sat_count;

endmodule

// File: tb/tb_fix14_to_ulaw_enc.sv
// Directed bench for fix14_to_ulaw_enc: hand-computed codes, stall/burst, saturation, reset.
`timescale 1ns/1ps
module tb_fix14_to_ulaw_enc;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [13:0]   in_data;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          out_sat;
  logic          sat_clr;
  logic [CW-1:0] sat_count;

  typedef struct {
    logic [7:0] code;
    logic       sat;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic burst_done;

  // Burst vectors: value, expected complemented code (all unclipped).
  int         burst_val [16] = '{0, 1, 30, 31, 94, 95, 222, 223, 1000, 4000, 5000,
                                 -100, -30, -1000, -5000, -8158};
  logic [7:0] burst_code[16] = '{8'hFF, 8'hFE, 8'hF0, 8'hEF, 8'hE0, 8'hDF, 8'hD0, 8'hCF,
                                 8'hAF, 8'h90, 8'h8C, 8'h5F, 8'h70, 8'h2F, 8'h0C, 8'h00};

  fix14_to_ulaw_enc #(.SAT_CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .sat_clr   (sat_clr),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Present one sample until accepted; the expected result is queued at the handshake.
  task automatic drive(input int v, input logic [7:0] code, input logic sat);
    bit accepted = 1'b0;
    in_data  = 14'(v);
    in_valid = 1'b1;
    for (int k = 0; k < 60 && !accepted; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{code, sat});
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) check("accept_timeout", 32'(accepted), 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Output monitor: scoreboard on each transfer, stability while stalled.
  initial begin
    exp_t       e;
    logic       held = 1'b0;
    logic [7:0] held_data = '0;
    logic       held_sat = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_data", 32'(out_data), 32'(held_data));
          check("stall_sat", 32'(out_sat), 32'(held_sat));
        end
        held = 1'b0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_out", 32'(out_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("out_code", 32'(out_data), 32'(e.code));
            check("out_sat", 32'(out_sat), 32'(e.sat));
          end
        end else if (out_valid) begin
          held      = 1'b1;
          held_data = out_data;
          held_sat  = out_sat;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    sat_clr    = 1'b0;
    burst_done = 1'b0;

    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'hFF);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    check("rst_sat_count", 32'(sat_count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed single samples including both clip cases.
    drive(0,     8'hFF, 1'b0);
    drain();
    drive(100,   8'hDF, 1'b0);
    drive(-1,    8'h7E, 1'b0);
    drive(8158,  8'h80, 1'b0);
    drive(8191,  8'h80, 1'b1);
    drive(-8192, 8'h00, 1'b1);
    drain();
    check("sat_count_two", 32'(sat_count), 32'd2);

    // Back-to-back burst against a randomly stalling consumer.
    fork
      begin
        for (int i = 0; i < 16; i++) drive(burst_val[i], burst_code[i], 1'b0);
        burst_done = 1'b1;
      end
      begin
        while (!burst_done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("sat_count_burst", 32'(sat_count), 32'd2);

    // Drive the counter into saturation and confirm it holds.
    for (int i = 0; i < 16; i++) drive(8191, 8'h80, 1'b1);
    drain();
    check("sat_count_pinned", 32'(sat_count), 32'hF);

    // Clear coincident with a clipped output transfer.
    out_ready = 1'b0;
    drive(8191, 8'h80, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (out_valid) break;
      @(posedge clk);
      #1;
    end
    check("clr_pre_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    sat_clr   = 1'b1;
    @(posedge clk);
    #1 sat_clr = 1'b0;
    check("sat_count_cleared", 32'(sat_count), 32'd0);
    drive(-8192, 8'h00, 1'b1);
    drain();
    check("sat_count_after_clr", 32'(sat_count), 32'd1);

    // Reset with both stages full.
    out_ready = 1'b0;
    drive(100, 8'hDF, 1'b0);
    drive(-1,  8'h7E, 1'b0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'hFF);
    check("midrst_sat_count", 32'(sat_count), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    drive(-100, 8'h5F, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
